target_driver: RTL and testbench

//  Fifo_clock-domain consumer of the stimulus FIFO and producer of the result FIFO.

---
 rtl/target_driver.sv | 143 ++++++++++++++
 tb/tb_target_driver.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_driver.sv
// target_driver
//   Fifo_clock-domain engine that sits between the stimulus FIFO and the
//   result FIFO. It pops one stimulus word, drives the vector onto the
//   target-design inputs, holds it for N+1 cycles, and, if the word's
//   capture flag is set, samples the target outputs into the result FIFO.
//
//   Stimulus word layout:
//     [STF_WIDTH-1:0]                      vector for the target inputs
//     [STF_WIDTH+CYCLE_RANGE-1:STF_WIDTH]  hold count N
//     [STF_WIDTH+CYCLE_RANGE]              capture flag C
//
// Ports
//   clock          fifo_clock, all logic on the rising edge
//   reset_n        synchronous active-low reset
//   enable         allows fetching of new stimulus words
//   sfifo_rdreq    stimulus FIFO read request (single-cycle pulse)
//   sfifo_rdempty  stimulus FIFO empty
//   sfifo_dataq    stimulus word, valid the cycle after sfifo_rdreq
//   rfifo_data     captured result word
//   rfifo_wrreq    result FIFO write request
//   rfifo_wrfull   result FIFO full
//   target_out     vector driven to the target inputs
//   target_in      target outputs, already synchronised upstream
//   busy           high whenever the engine is not idle
//   vec_count      number of vectors applied since reset (wraps)

module target_driver #(
  parameter int STF_WIDTH   = 24,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int VCNT_WIDTH  = 16
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               enable,
  output logic                               sfifo_rdreq,
  input  logic                               sfifo_rdempty,
  input  logic [STF_WIDTH+CYCLE_RANGE:0]     sfifo_dataq,
  output logic [RTF_WIDTH-1:0]               rfifo_data,
  output logic                               rfifo_wrreq,
  input  logic                               rfifo_wrfull,
  output logic [STF_WIDTH-1:0]               target_out,
  input  logic [RTF_WIDTH-1:0]               target_in,
  output logic                               busy,
  output logic [VCNT_WIDTH-1:0]              vec_count
);

  localparam logic [VCNT_WIDTH-1:0]  VCNT_ONE = {{(VCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_RANGE-1:0] HOLD_ONE = {{(CYCLE_RANGE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    APPLY,
    PUSH
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [STF_WIDTH-1:0]   r_targetOut;
  logic [RTF_WIDTH-1:0]   r_resultData;
  logic [VCNT_WIDTH-1:0]  r_vecCount;
  logic [CYCLE_RANGE-1:0] r_holdCount;
  logic                   r_captureFlag;
  logic                   w_rdreq;
  logic                   w_wrreq;

  // State register plus the datapath registers that move with it. LOAD
  // latches the word fields, APPLY counts the hold down and, on the last
  // hold cycle of a capture word, samples the target outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_targetOut   <= '0;
      r_resultData  <= '0;
      r_vecCount    <= '0;
      r_holdCount   <= '0;
      r_captureFlag <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        LOAD: begin
          r_targetOut   <= sfifo_dataq[STF_WIDTH-1:0];
          r_holdCount   <= sfifo_dataq[STF_WIDTH +: CYCLE_RANGE];
          r_captureFlag <= sfifo_dataq[STF_WIDTH+CYCLE_RANGE];
          r_vecCount    <= r_vecCount + VCNT_ONE;
        end
        APPLY: begin
          if (r_holdCount != '0) begin
            r_holdCount <= r_holdCount - HOLD_ONE;
          end else if (r_captureFlag) begin
            r_resultData <= target_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and handshake decode. Read and write requests can only be
  // raised in IDLE and PUSH respectively, so they are mutually exclusive.
  always_comb begin
    w_nextState = r_state;
    w_rdreq     = 1'b0;
    w_wrreq     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !sfifo_rdempty) begin
          w_rdreq     = 1'b1;
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_nextState = APPLY;
      end
      APPLY: begin
        if (r_holdCount == '0) begin
          w_nextState = r_captureFlag ? PUSH : IDLE;
        end
      end
      PUSH: begin
        if (!rfifo_wrfull) begin
          w_wrreq     = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Requests are masked while reset is asserted so that a pending fetch
  // or push is dropped in the very cycle reset is seen.
  assign sfifo_rdreq = w_rdreq & reset_n;
  assign rfifo_wrreq = w_wrreq & reset_n;
  assign busy        = (r_state != IDLE);
  assign target_out  = r_targetOut;
  assign rfifo_data  = r_resultData;
  assign vec_count   = r_vecCount;

endmodule

// File: tb/tb_target_driver.sv
// tb_target_driver
//   Drives target_driver from a queue-based stimulus FIFO and checks every
//   cycle against a transaction-timeline model: a fetch at cycle T loads the
//   vector at T+2, the hold ends at T+2+N, and a capture word then waits in
//   push until the result FIFO has room. Directed scenarios add literal
//   expectations, followed by a randomized phase and a drain.

module tb_target_driver;

  localparam int STF = 24;
  localparam int RTF = 24;
  localparam int CR  = 5;
  localparam int VW  = 16;
  localparam int WW  = STF + CR + 1;

  logic           clock;
  logic           reset_n;
  logic           enable;
  logic           sfifo_rdreq;
  logic           sfifo_rdempty;
  logic [WW-1:0]  sfifo_dataq;
  logic [RTF-1:0] rfifo_data;
  logic           rfifo_wrreq;
  logic           rfifo_wrfull;
  logic [STF-1:0] target_out;
  logic [RTF-1:0] target_in;
  logic           busy;
  logic [VW-1:0]  vec_count;

  int total = 0;
  int bad   = 0;

  logic [WW-1:0]  fifoQ[$];
  bit             rdSeen = 1'b0;
  int             wrCount = 0;
  logic [RTF-1:0] lastWrData = '0;

  // Timeline model state
  int             cyc = 0;
  bit             mValid = 1'b0;
  bit             mActive = 1'b0;
  int             mFetch = 0;
  int             mApplyEnd = 0;
  logic [WW-1:0]  mWord = '0;
  logic [STF-1:0] mTarget = '0;
  logic [RTF-1:0] mData = '0;
  logic [VW-1:0]  mCount = '0;
  bit             mC;
  bit             inPush;
  bit             expRd;
  bit             expWr;

  target_driver #(
    .STF_WIDTH(STF),
    .RTF_WIDTH(RTF),
    .CYCLE_RANGE(CR),
    .VCNT_WIDTH(VW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .sfifo_rdreq(sfifo_rdreq),
    .sfifo_rdempty(sfifo_rdempty),
    .sfifo_dataq(sfifo_dataq),
    .rfifo_data(rfifo_data),
    .rfifo_wrreq(rfifo_wrreq),
    .rfifo_wrfull(rfifo_wrfull),
    .target_out(target_out),
    .target_in(target_in),
    .busy(busy),
    .vec_count(vec_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [WW-1:0] mkWord(input logic c, input logic [CR-1:0] n,
                                           input logic [STF-1:0] v);
    return {c, n, v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; the FIFO pops on a request seen in the previous cycle
  task automatic step();
    @(posedge clock);
    #1;
    if (rdSeen && fifoQ.size() > 0) sfifo_dataq = fifoQ.pop_front();
    sfifo_rdempty = (fifoQ.size() == 0);
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic full,
                               input logic [RTF-1:0] tin);
    reset_n      = rst;
    enable       = en;
    rfifo_wrfull = full;
    target_in    = tin;
  endtask

  task automatic pushWord(input logic [WW-1:0] w);
    fifoQ.push_back(w);
    sfifo_rdempty = 1'b0;
  endtask

  task automatic atNegedge();
    @(negedge clock);
  endtask

  // Per-cycle compare against the timeline model, then advance the model
  always @(negedge clock) begin
    cyc++;
    rdSeen = sfifo_rdreq;
    if (rfifo_wrreq) begin
      wrCount++;
      lastWrData = rfifo_data;
    end
    mC     = mWord[WW-1];
    inPush = mActive && mC && (cyc > mApplyEnd);
    expRd  = reset_n && !mActive && enable && !sfifo_rdempty;
    expWr  = reset_n && inPush && !rfifo_wrfull;
    if (mValid) begin
      checkOutput("model rdreq", 32'(sfifo_rdreq), 32'(expRd));
      checkOutput("model wrreq", 32'(rfifo_wrreq), 32'(expWr));
      checkOutput("model busy", 32'(busy), 32'(mActive));
      checkOutput("model target_out", 32'(target_out), 32'(mTarget));
      checkOutput("model rfifo_data", 32'(rfifo_data), 32'(mData));
      checkOutput("model vec_count", 32'(vec_count), 32'(mCount));
    end
    if (!reset_n) begin
      mValid  = 1'b1;
      mActive = 1'b0;
      mTarget = '0;
      mData   = '0;
      mCount  = '0;
    end else if (mValid) begin
      if (expRd && fifoQ.size() > 0) begin
        mActive   = 1'b1;
        mFetch    = cyc;
        mWord     = fifoQ[0];
        mApplyEnd = cyc + 2 + int'(mWord[STF +: CR]);
      end else if (mActive) begin
        if (cyc == mFetch + 1) begin
          mTarget = mWord[STF-1:0];
          mCount  = mCount + 16'd1;
        end
        if (cyc == mApplyEnd) begin
          if (mC) mData = target_in;
          else    mActive = 1'b0;
        end
        if (expWr) mActive = 1'b0;
      end
    end
  end

  int wrBase;

  initial begin
    sfifo_dataq   = '0;
    sfifo_rdempty = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h123456);
    pushWord(mkWord(1'b1, 5'd3, 24'hA5A5A5));

    // Reset held with a non-empty FIFO and enable high
    repeat (3) step();
    atNegedge();
    checkOutput("reset rdreq", 32'(sfifo_rdreq), 32'd0);
    checkOutput("reset wrreq", 32'(rfifo_wrreq), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset target_out", 32'(target_out), 32'd0);
    checkOutput("reset vec_count", 32'(vec_count), 32'd0);

    // Capture word N=3 fetched straight after reset release (cycle T)
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 24'h123456);
    atNegedge();
    checkOutput("t2 rdreq at T", 32'(sfifo_rdreq), 32'd1);
    repeat (2) step();
    atNegedge();
    checkOutput("t2 target at T+2", 32'(target_out), 32'hA5A5A5);
    repeat (3) step();
    atNegedge();
    checkOutput("t2 target at T+5", 32'(target_out), 32'hA5A5A5);
    checkOutput("t2 no early wrreq", 32'(rfifo_wrreq), 32'd0);
    step();
    atNegedge();
    checkOutput("t2 wrreq at T+6", 32'(rfifo_wrreq), 32'd1);
    checkOutput("t2 rfifo_data", 32'(rfifo_data), 32'h123456);
    checkOutput("t2 vec_count", 32'(vec_count), 32'd1);
    step();
    atNegedge();
    checkOutput("t2 single wrreq", 32'(rfifo_wrreq), 32'd0);
    checkOutput("t2 idle", 32'(busy), 32'd0);

    // No-capture word with N=0
    wrBase = wrCount;
    pushWord(mkWord(1'b0, 5'd0, 24'h000001));
    repeat (6) step();
    atNegedge();
    checkOutput("t3 target kept", 32'(target_out), 32'h000001);
    checkOutput("t3 vec_count", 32'(vec_count), 32'd2);
    checkOutput("t3 no wrreq", 32'(wrCount - wrBase), 32'd0);

    // Result FIFO full while in push
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 24'h00C0DE);
    wrBase = wrCount;
    pushWord(mkWord(1'b1, 5'd2, 24'hBEEF01));
    repeat (12) step();
    atNegedge();
    checkOutput("t4 stalled wrreq", 32'(rfifo_wrreq), 32'd0);
    checkOutput("t4 held data", 32'(rfifo_data), 32'h00C0DE);
    checkOutput("t4 busy in push", 32'(busy), 32'd1);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 24'h00C0DE);
    repeat (3) step();
    atNegedge();
    checkOutput("t4 one write", 32'(wrCount - wrBase), 32'd1);
    checkOutput("t4 written data", 32'(lastWrData), 32'h00C0DE);

    // enable dropped during a long apply
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 24'h0A0B0C);
    wrBase = wrCount;
    pushWord(mkWord(1'b1, 5'd7, 24'h777777));
    pushWord(mkWord(1'b1, 5'd1, 24'h111111));
    pushWord(mkWord(1'b0, 5'd0, 24'h222222));
    repeat (4) step();
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h0A0B0C);
    repeat (20) step();
    atNegedge();
    checkOutput("t5 words left", 32'(fifoQ.size()), 32'd2);
    checkOutput("t5 one write", 32'(wrCount - wrBase), 32'd1);
    checkOutput("t5 written data", 32'(lastWrData), 32'h0A0B0C);
    checkOutput("t5 idle", 32'(busy), 32'd0);
    checkOutput("t5 vec_count", 32'(vec_count), 32'd4);

    // Reset while stalled in push
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 24'h555555);
    repeat (8) step();
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h555555);
    atNegedge();
    checkOutput("t6 wrreq in reset", 32'(rfifo_wrreq), 32'd0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 24'h555555);
    atNegedge();
    checkOutput("t6 target after reset", 32'(target_out), 32'd0);
    checkOutput("t6 data after reset", 32'(rfifo_data), 32'd0);
    checkOutput("t6 vec after reset", 32'(vec_count), 32'd0);
    checkOutput("t6 refetch rdreq", 32'(sfifo_rdreq), 32'd1);
    repeat (6) step();
    atNegedge();
    checkOutput("t6 next vector", 32'(target_out), 32'h222222);
    checkOutput("t6 vec_count", 32'(vec_count), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step();
      applyStimulus(($urandom_range(63) != 0), ($urandom_range(9) < 8),
                    ($urandom_range(9) < 3), 24'($urandom));
      if (fifoQ.size() < 3 && $urandom_range(3) == 0)
        pushWord(mkWord(1'($urandom_range(1)), 5'($urandom_range(31)), 24'($urandom)));
    end

    // Drain everything that is still queued
    for (int i = 0; i < 300; i++) begin
      step();
      applyStimulus(1'b1, 1'b1, 1'b0, 24'($urandom));
    end
    atNegedge();
    checkOutput("drain fifo empty", 32'(fifoQ.size()), 32'd0);
    checkOutput("drain idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
